c1_logic_cell: RTL and testbench

- Programmable-logic "C-module" cell: two-level 2:1 multiplexer tree, the basic combinational element of the FPGA-programmed neural-network fabric.
- First level: input pair A selected by SA, input pair B selected by SB.
- Second level: chooses between the A and B results using (S0 OR S1).
- Provides a combinational output f plus an optional registered copy, so cells can be chained into pipelined datapaths.

---
 rtl/c1_logic_cell.sv | 39 +++
 tb/tb_c1_logic_cell.sv | 85 ++++++++
 2 files changed

// File: rtl/c1_logic_cell.sv
// c1_logic_cell: per-slice two-level 2:1 mux tree (A/B pairs, then (S0|S1) picks B)
// with an optional enable-gated, async-cleared output register.
module c1_logic_cell #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] S0,
    input  logic [WIDTH-1:0] S1,
    input  logic [WIDTH-1:0] SA,
    input  logic [WIDTH-1:0] SB,
    input  logic             en,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q
);
    logic [WIDTH-1:0] a, b;

    // Per-bit ternaries so an unknown select propagates as X rather than being masked.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign a[i] = SA[i] ? A1[i] : A0[i];
        assign b[i] = SB[i] ? B1[i] : B0[i];
        assign f[i] = (S0[i] | S1[i]) ? b[i] : a[i];
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] r;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r <= '0;
            else if (en) r <= f;
        assign f_q = r;
    end else begin : g_comb
        assign f_q = f;
    end
endmodule

// File: tb/tb_c1_logic_cell.sv
// tb_c1_logic_cell: directed checks of the mux tree, output register, enable and async reset.
module tb_c1_logic_cell;
    logic clk = 0, rst_n = 0, en = 0;
    logic A0 = 0, A1 = 0, B0 = 0, B1 = 0, S0 = 0, S1 = 0, SA = 0, SB = 0;
    logic f, f_q;
    int errors = 0, checks = 0;

    c1_logic_cell #(.WIDTH(1), .REG_OUT(1)) dut (
        .clk(clk), .rst_n(rst_n), .A0(A0), .A1(A1), .B0(B0), .B1(B1),
        .S0(S0), .S1(S1), .SA(SA), .SB(SB), .en(en), .f(f), .f_q(f_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        logic e;
        #2 check("reset_fq", f_q, 1'b0);
        #1 rst_n = 1;
        A0 = 0; A1 = 1; SA = 1; B0 = 0; B1 = 1; SB = 0; S0 = 1; S1 = 1;
        #1 check("b_path_f", f, 1'b0);
        en = 1;
        step();
        check("b_path_fq", f_q, 1'b0);
        S0 = 0; S1 = 0;
        #1 check("a_path_f", f, 1'b1);
        step();
        check("a_path_fq", f_q, 1'b1);
        for (int s = 0; s < 4; s++) begin
            {S0, S1} = 2'(s);
            #1 check($sformatf("sel_sweep_%0d", s), f, s == 0 ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 256; k++) begin
            v = 8'(k);
            {A0, A1, B0, B1, S0, S1, SA, SB} = v;
            e = (~(v[3] | v[2]) & ((v[1] & v[6]) | (~v[1] & v[7])))
              | ((v[3] | v[2]) & ((v[0] & v[4]) | (~v[0] & v[5])));
            #1 check($sformatf("sweep_%0d", k), f, e);
        end
        A0 = 0; A1 = 1; SA = 1; B0 = 0; B1 = 1; SB = 0; S0 = 0; S1 = 0;
        step();
        check("pre_reset_fq", f_q, 1'b1);
        #2 rst_n = 0;
        #1 check("async_reset_fq", f_q, 1'b0);
        check("reset_f_tracks", f, 1'b1);
        step();
        check("reset_hold_fq_1", f_q, 1'b0);
        step();
        check("reset_hold_fq_2", f_q, 1'b0);
        #2 rst_n = 1;
        step();
        check("release_load_fq", f_q, 1'b1);
        en = 0;
        S0 = 1;
        #1 check("hold_f", f, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("hold_fq_%0d", c), f_q, 1'b1);
        end
        en = 1;
        step();
        check("enable_load_fq", f_q, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
